// File: rtl/booth_pkg.sv
// Shared definitions for the Booth recoding controller: FSM states and
// digit-count helpers used by the controller, the datapath and benches.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ANSWER,
        DONE
    } state_t;

    // Unsigned operands need one extra zero-extension bit before recoding.
    function automatic int nd_u(input int y_width, input int radix_log2);
        return (y_width + radix_log2) / radix_log2;
    endfunction

    function automatic int nd_s(input int y_width, input int radix_log2);
        return (y_width + radix_log2 - 1) / radix_log2;
    endfunction

    function automatic int idx_w(input int y_width, input int radix_log2);
        int w;
        w = $clog2(nd_u(y_width, radix_log2));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/booth_seq_ctrl.sv
// Sequencing FSM for a Booth multiplier recoder: loads the operand, walks
// through the recoded digits with downstream back-pressure, then pulses done.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int Y_WIDTH    = 8,
    parameter int RADIX_LOG2 = 2,
    localparam int IDX_W     = idx_w(Y_WIDTH, RADIX_LOG2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic             abort,
    input  logic             out_ready,
    output logic             busy,
    output logic             load,
    output logic             digit_valid,
    output logic [IDX_W-1:0] digit_idx,
    output logic             last_digit,
    output logic             shift_en,
    output logic             done
);

    localparam int ND_U = nd_u(Y_WIDTH, RADIX_LOG2);
    localparam int ND_S = nd_s(Y_WIDTH, RADIX_LOG2);
    localparam logic [IDX_W-1:0] LAST_U = IDX_W'(ND_U - 1);
    localparam logic [IDX_W-1:0] LAST_S = IDX_W'(ND_S - 1);

    if (RADIX_LOG2 != 1 && RADIX_LOG2 != 2) begin : g_bad_radix
        $error("booth_seq_ctrl: RADIX_LOG2 must be 1 or 2");
    end
    if (Y_WIDTH < 2 || Y_WIDTH > 64) begin : g_bad_width
        $error("booth_seq_ctrl: Y_WIDTH must be in 2..64");
    end

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             mode, mode_nx;
    logic [IDX_W-1:0] last_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            digit_idx <= '0;
            mode      <= 1'b0;
        end else begin
            state     <= state_nx;
            digit_idx <= idx_nx;
            mode      <= mode_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = digit_idx;
        mode_nx     = mode;
        busy        = (state != IDLE);
        load        = 1'b0;
        digit_valid = 1'b0;
        last_digit  = 1'b0;
        shift_en    = 1'b0;
        done        = 1'b0;
        last_idx    = mode ? LAST_U : LAST_S;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = LOAD;
                    mode_nx  = is_unsigned;
                    idx_nx   = '0;
                end
            end
            LOAD: begin
                load     = !abort;
                state_nx = ANSWER;
            end
            ANSWER: begin
                digit_valid = 1'b1;
                last_digit  = (digit_idx == last_idx);
                if (out_ready) begin
                    if (digit_idx != last_idx) begin
                        idx_nx   = digit_idx + 1'b1;
                        shift_en = !abort;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
                idx_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase

        // Abort overrides every transition decided above.
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end
    end

endmodule
